// File: rtl/vga_pkg.sv
// vga_pkg: default 1080p raster timing, pattern-mode encoding and the colour-bar palette.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 1920;
  localparam int H_FP_DEF     = 88;
  localparam int H_SYNC_DEF   = 44;
  localparam int H_BP_DEF     = 148;
  localparam int V_ACTIVE_DEF = 1080;
  localparam int V_FP_DEF     = 4;
  localparam int V_SYNC_DEF   = 5;
  localparam int V_BP_DEF     = 36;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_SOLID = 2'd2,
    MODE_GRAD  = 2'd3
  } pattern_mode_t;

  // {r,g,b} on/off for each bar, left to right; channels go to full scale when on.
  function automatic logic [2:0] bar_palette(input logic [2:0] idx);
    logic [2:0] rgb_on;
    case (idx)
      3'd0:    rgb_on = 3'b111;
      3'd1:    rgb_on = 3'b110;
      3'd2:    rgb_on = 3'b011;
      3'd3:    rgb_on = 3'b010;
      3'd4:    rgb_on = 3'b101;
      3'd5:    rgb_on = 3'b100;
      3'd6:    rgb_on = 3'b001;
      default: rgb_on = 3'b000;
    endcase
    return rgb_on;
  endfunction

endpackage

// File: rtl/vga_pattern.sv
// vga_pattern: combinational test-pattern colour for one active pixel.
// Only instantiated when VGA_PATTERN_EN is defined.
module vga_pattern
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int COLOR_W    = 4,
  parameter int CHECK_LOG2 = 5,
  parameter int CW         = 12
) (
  input  logic [CW-1:0]        x,
  input  logic [CW-1:0]        y,
  input  logic                 active,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  input  logic [2:0]           bar_idx,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue
);

  // Shift that makes the gradient ramp span the whole active width.
  localparam int CW_SHIFT = ($clog2(H_ACTIVE) > COLOR_W) ? ($clog2(H_ACTIVE) - COLOR_W) : 0;

  pattern_mode_t        mode_s;
  logic [2:0]           bar_on_s;
  logic                 check_s;
  logic [COLOR_W-1:0]   grad_s;
  logic                 unused_s;

  assign mode_s   = pattern_mode_t'(mode);
  assign bar_on_s = bar_palette(bar_idx);
  assign check_s  = x[CHECK_LOG2] ^ y[CHECK_LOG2];
  assign grad_s   = x[COLOR_W+CW_SHIFT-1:CW_SHIFT];
  assign unused_s = ^{x, y};

  // Colour select by latched mode; black outside the active area.
  always_comb begin
    red   = {COLOR_W{1'b0}};
    green = {COLOR_W{1'b0}};
    blue  = {COLOR_W{1'b0}};
    if (active) begin
      case (mode_s)
        MODE_BARS: begin
          red   = {COLOR_W{bar_on_s[2]}};
          green = {COLOR_W{bar_on_s[1]}};
          blue  = {COLOR_W{bar_on_s[0]}};
        end
        MODE_CHECK: begin
          red   = {COLOR_W{check_s}};
          green = {COLOR_W{check_s}};
          blue  = {COLOR_W{check_s}};
        end
        MODE_SOLID: begin
          {red, green, blue} = solid_rgb;
        end
        MODE_GRAD: begin
          red   = grad_s;
          green = grad_s;
          blue  = grad_s;
        end
        default: begin
          red   = {COLOR_W{1'b0}};
          green = {COLOR_W{1'b0}};
          blue  = {COLOR_W{1'b0}};
        end
      endcase
    end else begin
      red   = {COLOR_W{1'b0}};
      green = {COLOR_W{1'b0}};
      blue  = {COLOR_W{1'b0}};
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, registered sync/DE/coordinates and pixel colour.
// Define VGA_PATTERN_EN to build in the test-pattern source; otherwise ext_rgb is passed through.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE   = H_ACTIVE_DEF,
  parameter int   H_FP       = H_FP_DEF,
  parameter int   H_SYNC     = H_SYNC_DEF,
  parameter int   H_BP       = H_BP_DEF,
  parameter int   V_ACTIVE   = V_ACTIVE_DEF,
  parameter int   V_FP       = V_FP_DEF,
  parameter int   V_SYNC     = V_SYNC_DEF,
  parameter int   V_BP       = V_BP_DEF,
  parameter logic HS_POL     = 1'b0,
  parameter logic VS_POL     = 1'b0,
  parameter int   COLOR_W    = 4,
  parameter int   N_BARS     = 8,
  parameter int   CHECK_LOG2 = 5,
  parameter int   CW         = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  input  logic [3*COLOR_W-1:0] ext_rgb,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [CW-1:0]        x,
  output logic [CW-1:0]        y,
  output logic                 frame_start,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CW-1:0] ZERO_C     = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C      = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] H_LAST_C   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST_C   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_C   = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_C   = CW'(V_SYNC);
  localparam logic [CW-1:0] HA_START_C = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] HA_END_C   = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] VA_START_C = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] VA_END_C   = CW'(V_SYNC + V_BP + V_ACTIVE);

  logic [CW-1:0]        h_r;
  logic [CW-1:0]        v_r;
  logic                 active_s;
  logic                 origin_s;
  logic [CW-1:0]        x_s;
  logic [CW-1:0]        y_s;
  logic [3*COLOR_W-1:0] rgb_s;
  logic                 unused_s;

  assign active_s = (h_r >= HA_START_C) && (h_r < HA_END_C) &&
                    (v_r >= VA_START_C) && (v_r < VA_END_C);
  assign origin_s = (h_r == ZERO_C) && (v_r == ZERO_C);
  assign x_s      = active_s ? (h_r - HA_START_C) : ZERO_C;
  assign y_s      = active_s ? (v_r - VA_START_C) : ZERO_C;

  // Raster counters: h wraps every line, v steps on the last clock of each line.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_r <= ZERO_C;
      v_r <= ZERO_C;
    end else if (h_r == H_LAST_C) begin
      h_r <= ZERO_C;
      v_r <= (v_r == V_LAST_C) ? ZERO_C : (v_r + ONE_C);
    end else begin
      h_r <= h_r + ONE_C;
    end
  end

`ifdef VGA_PATTERN_EN
  localparam logic [CW-1:0] BAR_LAST_C = CW'(H_ACTIVE / N_BARS - 1);
  localparam logic [2:0]    LAST_BAR_C = 3'(N_BARS - 1);

  logic [1:0]           mode_r;
  logic [3*COLOR_W-1:0] solid_r;
  logic [CW-1:0]        bar_pos_r;
  logic [2:0]           bar_idx_r;

  // Pattern controls are sampled once per frame at the raster origin.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r  <= MODE_BARS;
      solid_r <= {(3*COLOR_W){1'b0}};
    end else if (origin_s) begin
      mode_r  <= mode;
      solid_r <= solid_rgb;
    end
  end

  // Bar index steps every BAR_W active pixels; the final bar keeps any remainder.
  always_ff @(posedge clk) begin
    if (rst || !active_s) begin
      bar_pos_r <= ZERO_C;
      bar_idx_r <= 3'd0;
    end else if ((bar_pos_r == BAR_LAST_C) && (bar_idx_r != LAST_BAR_C)) begin
      bar_pos_r <= ZERO_C;
      bar_idx_r <= bar_idx_r + 3'd1;
    end else begin
      bar_pos_r <= bar_pos_r + ONE_C;
    end
  end

  vga_pattern #(
    .H_ACTIVE   (H_ACTIVE),
    .COLOR_W    (COLOR_W),
    .CHECK_LOG2 (CHECK_LOG2),
    .CW         (CW)
  ) u_pattern (
    .x         (x_s),
    .y         (y_s),
    .active    (active_s),
    .mode      (mode_r),
    .solid_rgb (solid_r),
    .bar_idx   (bar_idx_r),
    .red       (rgb_s[3*COLOR_W-1:2*COLOR_W]),
    .green     (rgb_s[2*COLOR_W-1:COLOR_W]),
    .blue      (rgb_s[COLOR_W-1:0])
  );

  assign unused_s = ^ext_rgb;
`else
  assign rgb_s    = ext_rgb;
  assign unused_s = ^{mode, solid_rgb, N_BARS[0], CHECK_LOG2[0]};
`endif

  // Every output is registered from the same counter state so they stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync              <= ~HS_POL;
      vsync              <= ~VS_POL;
      de                 <= 1'b0;
      x                  <= ZERO_C;
      y                  <= ZERO_C;
      frame_start        <= 1'b0;
      {red, green, blue} <= {(3*COLOR_W){1'b0}};
    end else begin
      hsync              <= (h_r < H_SYNC_C) ? HS_POL : ~HS_POL;
      vsync              <= (v_r < V_SYNC_C) ? VS_POL : ~VS_POL;
      de                 <= active_s;
      x                  <= x_s;
      y                  <= y_s;
      frame_start        <= origin_s;
      {red, green, blue} <= active_s ? rgb_s : {(3*COLOR_W){1'b0}};
    end
  end

endmodule
